// File: rtl/block_latency_memory_pkg.sv
// Shared types and helpers for the block-latency backing store.
// Holds the FSM state encoding and width helpers used by the top and the counter.
package block_latency_memory_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

  // Never returns zero, so a parameter of 1 still yields a legal vector width.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/block_latency_memory_counter.sv
// Latency down-counter: loads DELAY-1 on start, decrements while enabled,
// and flags terminal count. Also usable by cache-side timeout logic.
module block_latency_memory_counter
  import block_latency_memory_pkg::*;
#(
  parameter int DELAY = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic enable,
  output logic expired
);

  localparam int CW = clog2_min1(DELAY + 1);
  localparam logic [CW-1:0] LOAD = CW'(DELAY - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (reset) begin
      count_d = '0;
    end else if (start) begin
      count_d = LOAD;
    end else if (enable && (count_q != '0)) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/block_latency_memory.sv
// Line-granular backing store that completes one read or write per request
// after a fixed DELAY, giving the cache a tunable and exactly timed responder.
//
//   state    | meaning
//   MEM_IDLE | ready; accepts a request carrying a read or write op
//   MEM_WAIT | latency countdown; write commits / read data loads on expiry
//   MEM_DONE | one-cycle completion; read data valid here only
module block_latency_memory
  import block_latency_memory_pkg::*;
#(
  parameter int BLOCK_SIZE = 16,
  parameter int NUM_BLOCKS = 1024,
  parameter int DELAY      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    is_input_valid,
  input  logic [31:0]             addr,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [BLOCK_SIZE*8-1:0] din,
  output logic                    is_output_valid,
  output logic [BLOCK_SIZE*8-1:0] dout,
  output logic                    mem_ready
);

  localparam int W  = BLOCK_SIZE * 8;
  localparam int IW = clog2_min1(NUM_BLOCKS);

  mem_state_e    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          is_wr_q, is_wr_d;
  logic [W-1:0]  wdata_q, wdata_d;
  logic          valid_q, valid_d;
  logic [W-1:0]  dout_q, dout_d;
  logic [W-1:0]  mem_q [NUM_BLOCKS];
  logic          mem_we;
  logic          cnt_start;
  logic          cnt_expired;
  logic          unused_addr;

  // Upper address bits alias onto the array by design.
  assign unused_addr = ^addr;

  block_latency_memory_counter #(.DELAY(DELAY)) u_counter (
    .clk     (clk),
    .reset   (reset),
    .start   (cnt_start),
    .enable  (state_q == MEM_WAIT),
    .expired (cnt_expired)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    is_wr_d   = is_wr_q;
    wdata_d   = wdata_q;
    valid_d   = 1'b0;
    dout_d    = dout_q;
    mem_we    = 1'b0;
    cnt_start = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        if (is_input_valid && (mem_read || mem_write)) begin
          idx_d     = addr[IW-1:0];
          is_wr_d   = mem_write;
          wdata_d   = din;
          cnt_start = 1'b1;
          state_d   = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (cnt_expired) begin
          state_d = MEM_DONE;
          if (is_wr_q) begin
            mem_we = 1'b1;
          end else begin
            dout_d  = mem_q[idx_q];
            valid_d = 1'b1;
          end
        end
      end
      MEM_DONE: state_d = MEM_IDLE;
      default:  state_d = MEM_IDLE;
    endcase
    // Reset wins over everything, including a write due to commit this edge.
    if (reset) begin
      state_d   = MEM_IDLE;
      valid_d   = 1'b0;
      dout_d    = '0;
      mem_we    = 1'b0;
      cnt_start = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    idx_q   <= idx_d;
    is_wr_q <= is_wr_d;
    wdata_q <= wdata_d;
    valid_q <= valid_d;
    dout_q  <= dout_d;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign is_output_valid = valid_q;
  assign dout            = dout_q;
  assign mem_ready       = (state_q == MEM_IDLE);

endmodule
